timer_irq_arb: RTL and testbench
================================

// Module: timer_irq_arb
// PURPOSE
//  Shares the single CPU interrupt line between N_CH timer channels.
//  - Latches each channel's done pulse into a pending bit when that channel's interrupt enable is set.
//  - Picks one pending channel by round-robin and raises irq with its id.
//  - Runs a claim/complete handshake with the CPU; sticky overrun flags record any lost events.
// PARAMETERS
//  N_CH  4                       number of timer channels, legal range 2..16
//  IDW   $clog2(N_CH) (derived)  width of irq_id, localparam
// PORTS
//  clk          in   1     system clock, all logic on posedge
//  rst          in   1     asynchronous active-low reset
//  ch_done      in   N_CH  per-channel count-finished, 1-cycle pulse
//  ch_int_en    in   N_CH  per-channel interrupt enable
//  claim        in   1     CPU takes the current irq_id, 1-cycle pulse
//  complete     in   1     CPU finished servicing, 1-cycle pulse
//  clr_overrun  in   N_CH  write-1-to-clear for overrun bits
//  irq          out  1     interrupt to CPU, level
//  irq_id       out  IDW   channel being signalled, valid while irq=1 and in SERVICE
//  pending      out  N_CH  pending flags, registered
//  overrun      out  N_CH  sticky lost-event flags, registered
// BEHAVIOUR
//  Reset (rst=0, asynchronous)
//   - irq=0, irq_id=0, pending=0, overrun=0, state=IDLE, last_id=N_CH-1.
//   - Mid-operation reset drops everything; nothing resumes after release.
//  Pending bits
//   - Set: pending[i] <= 1 when ch_done[i] & ch_int_en[i].
//   - ch_done[i] with ch_int_en[i]=0 is ignored and leaves no trace.
//   - Clear: pending[irq_id] clears on an accepted claim.
//   - Same-cycle set and clear on one bit: set wins, bit stays 1, no overrun.
//   - Clearing ch_int_en does not clear an existing pending bit.
//  Overrun bits
//   - Set: overrun[i] <= 1 when the set condition hits while pending[i] is already 1 and not being cleared that cycle.
//   - Clear: clr_overrun[i] clears the bit.
//   - Same-cycle set and clear: set wins.
//  FSM: IDLE, ASSERT, SERVICE
//   - IDLE: if |pending, latch irq_id from the round-robin pick, go to ASSERT. Otherwise stay.
//   - ASSERT: irq=1. On claim: clear pending[irq_id], set last_id=irq_id, go to SERVICE.
//   - SERVICE: irq=0, irq_id held. On complete, go to IDLE.
//   - claim outside ASSERT is ignored; complete outside SERVICE is ignored.
//   - claim and complete in the same cycle: only the event legal for the current state acts.
//  Round-robin pick
//   - Take the first set pending bit, scanning from (last_id+1) mod N_CH upward with wrap.
//   - Combinational over the registered pending vector.
//   - New pending bits that arrive while in ASSERT do not change irq_id.
//  Registered outputs
//   - irq is a registered output: irq = (state==ASSERT).
//  Timing
//   - ch_done high in cycle k gives pending=1 in k+1 and irq=1 in k+2 (from IDLE).
//   - claim in cycle m gives irq=0 and the pending bit cleared in m+1.
//   - complete in cycle n gives IDLE in n+1 and the next irq no earlier than n+2.
// TESTING
//  T1 single event: N_CH=4, int_en=4'b1111, ch_done=4'b0100 one cycle
//     -> pending=4'b0100 next cycle; irq=1, irq_id=2 one cycle later
//     -> claim: irq=0, pending=0 -> complete: FSM back to IDLE.
//  T2 round-robin fairness: pending=4'b1111 after reset
//     -> four claim/complete rounds service ids 0,1,2,3
//     -> re-pend 0 and 3 with last_id=3 -> id 0 served before 3.
//  T3 masking: ch_done=4'b0001 with int_en=4'b0000
//     -> pending=0, irq stays 0, overrun=0.
//  T4 overrun: pending[1]=1 in ASSERT for id 0, pulse ch_done[1]
//     -> overrun=4'b0010; clr_overrun=4'b0010 -> overrun=0.
//  T5 set/clear collision: in ASSERT id=2, claim and ch_done[2] in the same cycle
//     -> pending[2] stays 1, overrun[2]=0, irq re-asserts with id 2 after complete.
//  T6 reset mid-service: drop rst while in SERVICE with pending=4'b1010
//     -> all outputs 0 immediately (async)
//     -> after release with no new ch_done, irq stays 0.

Source files
------------

// File: rtl/timer_irq_arb.sv
// Timer interrupt arbiter: latches per-channel done pulses into pending bits and
// hands them to the CPU one at a time via round-robin and a claim/complete handshake.
module timer_irq_arb #(
  parameter  int N_CH = 4,
  localparam int IDW  = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] ch_done,
  input  logic [N_CH-1:0] ch_int_en,
  input  logic            claim,
  input  logic            complete,
  input  logic [N_CH-1:0] clr_overrun,
  output logic            irq,
  output logic [IDW-1:0]  irq_id,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] overrun
);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_irq;
  logic [IDW-1:0]  r_irq_id, r_last_id, w_pick;
  logic [N_CH-1:0] r_pending, r_overrun;
  logic [N_CH-1:0] w_set, w_clr, w_ov_set;
  logic            w_load_id, w_claim_ok, w_found;

  // Scan starts one past the last serviced id so every channel gets a turn.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      logic [IDW-1:0] w_cand;
      w_cand = IDW'((int'(r_last_id) + k) % N_CH);
      if (!w_found && r_pending[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_id   = 1'b0;
    w_claim_ok  = 1'b0;
    case (r_state)
      S_IDLE:    if (|r_pending) begin w_state_nxt = S_ASSERT; w_load_id = 1'b1; end
      S_ASSERT:  if (claim) begin w_state_nxt = S_SERVICE; w_claim_ok = 1'b1; end
      S_SERVICE: if (complete) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign w_set    = ch_done & ch_int_en;
  assign w_clr    = w_claim_ok ? (N_CH'(1) << r_irq_id) : '0;
  // A new event on a bit that stays pending means one event is lost.
  assign w_ov_set = w_set & r_pending & ~w_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_irq     <= 1'b0;
      r_irq_id  <= '0;
      r_last_id <= IDW'(N_CH - 1);
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_irq     <= (w_state_nxt == S_ASSERT);
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_overrun <= (r_overrun & ~clr_overrun) | w_ov_set;
      if (w_load_id)  r_irq_id  <= w_pick;
      if (w_claim_ok) r_last_id <= r_irq_id;
    end
  end

  assign irq     = r_irq;
  assign irq_id  = r_irq_id;
  assign pending = r_pending;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_timer_irq_arb.sv
// Bench for timer_irq_arb: per-cycle vector table with expected outputs queued
// at drive time and compared after each edge, plus an async mid-service reset.
module tb_timer_irq_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ch_done, ch_int_en, clr_overrun;
  logic       claim, complete;
  logic       irq;
  logic [1:0] irq_id;
  logic [3:0] pending, overrun;

  typedef struct {
    logic [3:0] done, en, clr;
    logic       clm, cmp;
    logic       e_irq;
    logic [1:0] e_id;
    logic [3:0] e_pend, e_ov;
  } vec_t;

  typedef struct {
    logic       irq;
    logic [1:0] id;
    logic [3:0] pend, ov;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  timer_irq_arb #(.N_CH(4)) dut (
    .clk(clk), .rst(rst), .ch_done(ch_done), .ch_int_en(ch_int_en),
    .claim(claim), .complete(complete), .clr_overrun(clr_overrun),
    .irq(irq), .irq_id(irq_id), .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] d, input logic [3:0] en,
                              input logic c, input logic p, input logic [3:0] clr,
                              input logic ei, input logic [1:0] eid,
                              input logic [3:0] ep, input logic [3:0] eo);
    vec_t v;
    v.done = d; v.en = en; v.clm = c; v.cmp = p; v.clr = clr;
    v.e_irq = ei; v.e_id = eid; v.e_pend = ep; v.e_ov = eo;
    return v;
  endfunction

  task automatic push_exp(input logic ei, input logic [1:0] eid,
                          input logic [3:0] ep, input logic [3:0] eo);
    exp_t e;
    e.irq = ei; e.id = eid; e.pend = ep; e.ov = eo;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (irq !== e.irq) begin errors++; $display("FAIL %s irq: got %b want %b", tag, irq, e.irq); end
    checks++;
    if (irq_id !== e.id) begin errors++; $display("FAIL %s irq_id: got %0d want %0d", tag, irq_id, e.id); end
    checks++;
    if (pending !== e.pend) begin errors++; $display("FAIL %s pending: got %b want %b", tag, pending, e.pend); end
    checks++;
    if (overrun !== e.ov) begin errors++; $display("FAIL %s overrun: got %b want %b", tag, overrun, e.ov); end
  endtask

  task automatic idle_inputs();
    ch_done = '0; claim = 1'b0; complete = 1'b0; clr_overrun = '0;
  endtask

  initial begin
    // T2 round-robin (starts right after reset so last_id=3)
    tv.push_back(mk(4'b1111, 4'hF, 0, 0, 0, 0, 0, 4'b1111, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 1, 0, 4'b1111, 0));
    tv.push_back(mk(4'b0000, 4'hF, 1, 0, 0, 0, 0, 4'b1110, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 1, 0, 0, 0, 4'b1110, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 1, 1, 4'b1110, 0));
    tv.push_back(mk(4'b0000, 4'hF, 1, 0, 0, 0, 1, 4'b1100, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 1, 0, 0, 1, 4'b1100, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 1, 2, 4'b1100, 0));
    tv.push_back(mk(4'b0000, 4'hF, 1, 0, 0, 0, 2, 4'b1000, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 1, 0, 0, 2, 4'b1000, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 1, 3, 4'b1000, 0));
    tv.push_back(mk(4'b0000, 4'hF, 1, 0, 0, 0, 3, 4'b0000, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 1, 0, 0, 3, 4'b0000, 0));
    tv.push_back(mk(4'b1001, 4'hF, 0, 0, 0, 0, 3, 4'b1001, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 1, 0, 4'b1001, 0));
    tv.push_back(mk(4'b0000, 4'hF, 1, 0, 0, 0, 0, 4'b1000, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 1, 0, 0, 0, 4'b1000, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 1, 3, 4'b1000, 0));
    tv.push_back(mk(4'b0000, 4'hF, 1, 0, 0, 0, 3, 4'b0000, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 1, 0, 0, 3, 4'b0000, 0));
    // T1 single event, then a stray claim in IDLE
    tv.push_back(mk(4'b0100, 4'hF, 0, 0, 0, 0, 3, 4'b0100, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 1, 2, 4'b0100, 0));
    tv.push_back(mk(4'b0000, 4'hF, 1, 0, 0, 0, 2, 4'b0000, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 1, 0, 0, 2, 4'b0000, 0));
    tv.push_back(mk(4'b0000, 4'hF, 1, 0, 0, 0, 2, 4'b0000, 0));
    // T3 masking, then enabling afterwards leaves no trace
    tv.push_back(mk(4'b0001, 4'h0, 0, 0, 0, 0, 2, 4'b0000, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 0, 2, 4'b0000, 0));
    // T4 overrun, stray complete in ASSERT, set-beats-clear, stray claim in SERVICE
    tv.push_back(mk(4'b0011, 4'hF, 0, 0, 0,       0, 2, 4'b0011, 4'b0000));
    tv.push_back(mk(4'b0000, 4'hF, 0, 0, 0,       1, 0, 4'b0011, 4'b0000));
    tv.push_back(mk(4'b0010, 4'hF, 0, 1, 0,       1, 0, 4'b0011, 4'b0010));
    tv.push_back(mk(4'b0000, 4'hF, 1, 0, 0,       0, 0, 4'b0010, 4'b0010));
    tv.push_back(mk(4'b0010, 4'hF, 0, 0, 4'b0010, 0, 0, 4'b0010, 4'b0010));
    tv.push_back(mk(4'b0000, 4'hF, 1, 0, 4'b0010, 0, 0, 4'b0010, 4'b0000));
    tv.push_back(mk(4'b0000, 4'hF, 0, 1, 0,       0, 0, 4'b0010, 4'b0000));
    tv.push_back(mk(4'b0000, 4'hF, 0, 0, 0,       1, 1, 4'b0010, 4'b0000));
    tv.push_back(mk(4'b0000, 4'hF, 1, 0, 0,       0, 1, 4'b0000, 4'b0000));
    tv.push_back(mk(4'b0000, 4'hF, 1, 1, 0,       0, 1, 4'b0000, 4'b0000));
    // T5 claim and ch_done on the same bit: set wins, no overrun
    tv.push_back(mk(4'b0100, 4'hF, 0, 0, 0, 0, 1, 4'b0100, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 1, 2, 4'b0100, 0));
    tv.push_back(mk(4'b0100, 4'hF, 1, 0, 0, 0, 2, 4'b0100, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 1, 0, 0, 2, 4'b0100, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 1, 2, 4'b0100, 0));
    tv.push_back(mk(4'b0000, 4'hF, 1, 0, 0, 0, 2, 4'b0000, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 1, 0, 0, 2, 4'b0000, 0));
    // T6 prologue: reach SERVICE with pending=1010
    tv.push_back(mk(4'b0010, 4'hF, 0, 0, 0, 0, 2, 4'b0010, 0));
    tv.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 1, 1, 4'b0010, 0));
    tv.push_back(mk(4'b0000, 4'hF, 1, 0, 0, 0, 1, 4'b0000, 0));
    tv.push_back(mk(4'b1010, 4'hF, 0, 0, 0, 0, 1, 4'b1010, 0));

    rst = 1'b0; ch_int_en = '0;
    idle_inputs();
    #12;
    push_exp(0, 0, 4'b0000, 4'b0000);
    pop_check("reset");
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      ch_done = tv[i].done; ch_int_en = tv[i].en; claim = tv[i].clm;
      complete = tv[i].cmp; clr_overrun = tv[i].clr;
      push_exp(tv[i].e_irq, tv[i].e_id, tv[i].e_pend, tv[i].e_ov);
      @(posedge clk); #1;
      pop_check($sformatf("vec%0d", i));
    end

    // T6: asynchronous reset between edges while in SERVICE
    @(negedge clk); idle_inputs();
    #2 rst = 1'b0;
    push_exp(0, 0, 4'b0000, 4'b0000);
    #1 pop_check("async_rst");
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_exp(0, 0, 4'b0000, 4'b0000);
      @(posedge clk); #1;
      pop_check($sformatf("post_rst%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
